// File: rtl/envelope_vca_if.sv
// Sample stream and envelope control bundle between the tone generator, the VCA and the voice mixer.
interface envelope_vca_if #(
   parameter int SAMPLE_BITS = 16
);
   logic [7:0]                    amplitude;
   logic signed [SAMPLE_BITS-1:0] in_sample;
   logic                          in_valid;
   logic                          in_ready;
   logic signed [SAMPLE_BITS-1:0] out_sample;
   logic                          out_valid;
   logic                          out_ready;
   logic                          idle;

   modport master (
      output amplitude, in_sample, in_valid, out_ready,
      input  in_ready, out_sample, out_valid, idle
   );

   modport slave (
      input  amplitude, in_sample, in_valid, out_ready,
      output in_ready, out_sample, out_valid, idle
   );
endinterface

// File: rtl/envelope_vca.sv
// Envelope-driven VCA: slew-limits the envelope level per accepted sample and scales samples in a two-stage pipe.
module envelope_vca #(
   parameter int SAMPLE_BITS = 16,
   parameter int SLEW_STEP   = 4
) (
   input logic           clk,
   input logic           rst,
   envelope_vca_if.slave vca
);
   localparam int         PW   = SAMPLE_BITS + 9;
   localparam logic [7:0] STEP = 8'(SLEW_STEP);

   logic [7:0]                    amp_s;
   logic [7:0]                    amp_next;
   logic [7:0]                    amp_diff;
   logic [8:0]                    gain_next;
   logic signed [SAMPLE_BITS-1:0] s1_sample;
   logic [8:0]                    s1_gain;
   logic                          s1_valid;
   logic signed [SAMPLE_BITS-1:0] out_sample_r;
   logic                          out_valid_r;
   logic                          idle_r;
   logic                          en;
   logic                          acc;
   logic signed [PW-1:0]          product;
   logic                          unused_product_bits;

   // The whole pipe advances unless a held output is still waiting for the mixer.
   assign en  = !(out_valid_r && !vca.out_ready);
   assign acc = vca.in_valid && en;

   assign vca.in_ready   = en;
   assign vca.out_sample = out_sample_r;
   assign vca.out_valid  = out_valid_r;
   assign vca.idle       = idle_r;

   // Step the gain toward the envelope target, landing exactly on it when the gap is within one step.
   always_comb begin
      amp_next = amp_s;
      amp_diff = 8'd0;
      if (vca.amplitude > amp_s) begin
         amp_diff = vca.amplitude - amp_s;
         amp_next = (amp_diff > STEP) ? amp_s + STEP : vca.amplitude;
      end else if (vca.amplitude < amp_s) begin
         amp_diff = amp_s - vca.amplitude;
         amp_next = (amp_diff > STEP) ? amp_s - STEP : vca.amplitude;
      end
   end

   // Full-scale level maps to 256 so that the top envelope value passes samples through unchanged.
   always_comb begin
      gain_next = (amp_next == 8'd255) ? 9'd256 : {1'b0, amp_next};
   end

   // Signed sample times non-negative gain; the slice below is an arithmetic shift by 8, flooring toward minus infinity.
   assign product = PW'(s1_sample) * PW'($signed({1'b0, s1_gain}));
   assign unused_product_bits = ^{product[PW-1], product[7:0]};

   // Slewed gain and idle flag only move when a sample is actually taken in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         amp_s  <= 8'd0;
         idle_r <= 1'b1;
      end else if (acc) begin
         amp_s  <= amp_next;
         idle_r <= (amp_next == 8'd0) && (vca.amplitude == 8'd0);
      end
   end

   // Stage 1 captures the accepted sample together with the gain it must be scaled by.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid  <= 1'b0;
         s1_sample <= '0;
         s1_gain   <= 9'd0;
      end else if (en) begin
         s1_valid <= acc;
         if (acc) begin
            s1_sample <= vca.in_sample;
            s1_gain   <= gain_next;
         end
      end
   end

   // Stage 2 registers the scaled sample and holds it until the mixer takes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_r  <= 1'b0;
         out_sample_r <= '0;
      end else if (en) begin
         out_valid_r <= s1_valid;
         if (s1_valid) begin
            out_sample_r <= product[SAMPLE_BITS+7:8];
         end
      end
   end
endmodule

// File: tb/tb_envelope_vca.sv
// Self-checking bench for envelope_vca: vector table plus hand sequences, outputs checked through a scoreboard queue.
module tb_envelope_vca;
   localparam int SB   = 16;
   localparam int STEP = 4;

   typedef struct {
      logic [7:0] amp;
      int         sample;
      bit         useModel;
      int         expOut;
      int         reps;
   } vec_t;

   logic clk;
   logic rst;
   int   checkCount;
   int   passCount;
   int   sb[$];
   logic [7:0] modelAmp;
   bit   curUseModel;
   int   curExp;
   vec_t vecs[$];
   int   frozen;

   envelope_vca_if #(.SAMPLE_BITS(SB)) vif ();

   envelope_vca #(
      .SAMPLE_BITS(SB),
      .SLEW_STEP  (STEP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vca(vif)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a stuck handshake can never hang the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int required);
      checkCount++;
      if (actual !== required) begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
      end else begin
         passCount++;
      end
   endtask

   function automatic logic [7:0] slewModel(input logic [7:0] cur, input logic [7:0] target);
      int d;
      d = int'(target) - int'(cur);
      if (d > STEP) d = STEP;
      if (d < -STEP) d = -STEP;
      return 8'(int'(cur) + d);
   endfunction

   // Scoreboard: pop and compare on each output handshake, push the expectation on each input accept.
   always @(negedge clk) begin
      int g;
      if (rst) begin
         if (vif.out_valid && vif.out_ready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpectedOutput", int'(vif.out_sample), 0);
            end else begin
               checkOutput("outSample", int'(vif.out_sample), sb.pop_front());
            end
         end
         if (vif.in_valid && vif.in_ready) begin
            modelAmp = slewModel(modelAmp, vif.amplitude);
            g = (modelAmp == 8'd255) ? 256 : int'(modelAmp);
            if (curUseModel) sb.push_back((int'(vif.in_sample) * g) >>> 8);
            else             sb.push_back(curExp);
         end
      end
   end

   task automatic applyStimulus(input bit v, input logic [7:0] a, input int s, input bit useModel, input int e);
      bit accepted;
      int waited;
      vif.in_valid  = v;
      vif.amplitude = a;
      vif.in_sample = SB'(s);
      curUseModel   = useModel;
      curExp        = e;
      accepted      = 1'b0;
      waited        = 0;
      while (!accepted) begin
         @(negedge clk);
         accepted = !v || vif.in_ready;
         @(posedge clk);
         #1;
         waited++;
         if (!accepted && waited > 50) begin
            checkOutput("acceptTimeout", 0, 1);
            accepted = 1'b1;
         end
      end
   endtask

   task automatic drain();
      vif.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      checkCount     = 0;
      passCount      = 0;
      modelAmp       = 8'd0;
      curUseModel    = 1'b1;
      curExp         = 0;
      vif.in_valid   = 1'b0;
      vif.amplitude  = 8'd0;
      vif.in_sample  = '0;
      vif.out_ready  = 1'b1;
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      checkOutput("resetOutValid", int'(vif.out_valid), 0);
      checkOutput("resetOutSample", int'(vif.out_sample), 0);
      checkOutput("resetIdle", int'(vif.idle), 1);
      checkOutput("resetInReady", int'(vif.in_ready), 1);
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;

      // Ramp from 0 toward 255, unity and sign cases, slew down to 128 and flooring checks, then settle at 8.
      vecs.push_back('{8'd255, 1000, 1'b0, 15, 1});
      vecs.push_back('{8'd255, 1000, 1'b0, 31, 1});
      vecs.push_back('{8'd255, 1000, 1'b0, 46, 1});
      vecs.push_back('{8'd255, 1000, 1'b0, 62, 1});
      vecs.push_back('{8'd255, 1000, 1'b0, 78, 1});
      vecs.push_back('{8'd255, 1000, 1'b0, 93, 1});
      vecs.push_back('{8'd255, 1000, 1'b0, 109, 1});
      vecs.push_back('{8'd255, 1000, 1'b0, 125, 1});
      vecs.push_back('{8'd255, 1000, 1'b1, 0, 55});
      vecs.push_back('{8'd255, 1000, 1'b0, 1000, 2});
      vecs.push_back('{8'd255, -32768, 1'b0, -32768, 1});
      vecs.push_back('{8'd255, 32767, 1'b0, 32767, 1});
      vecs.push_back('{8'd128, 0, 1'b1, 0, 32});
      vecs.push_back('{8'd128, -1, 1'b0, -1, 1});
      vecs.push_back('{8'd128, 3, 1'b0, 1, 1});
      vecs.push_back('{8'd8, 0, 1'b1, 0, 30});
      for (int i = 0; i < vecs.size(); i++) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            applyStimulus(1'b1, vecs[i].amp, vecs[i].sample, vecs[i].useModel, vecs[i].expOut);
         end
      end

      // Release from 8 to 0 in two slew steps; idle must rise exactly when the gain reaches 0.
      applyStimulus(1'b1, 8'd0, 5000, 1'b0, 78);
      checkOutput("idleBeforeZero", int'(vif.idle), 0);
      applyStimulus(1'b1, 8'd0, 5000, 1'b0, 0);
      checkOutput("idleAtZero", int'(vif.idle), 1);
      applyStimulus(1'b1, 8'd0, 5000, 1'b0, 0);
      drain();
      checkOutput("drainAfterRelease", sb.size(), 0);

      // Backpressure mid-stream: outputs freeze, input is refused, order stays intact.
      for (int s = 1; s <= 4; s++) applyStimulus(1'b1, 8'd255, s * 1000, 1'b1, 0);
      vif.out_ready = 1'b0;
      vif.in_valid  = 1'b1;
      vif.in_sample = SB'(5000);
      frozen = int'(vif.out_sample);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("stallInReady", int'(vif.in_ready), 0);
         checkOutput("stallOutValid", int'(vif.out_valid), 1);
         checkOutput("stallOutSample", int'(vif.out_sample), frozen);
         @(posedge clk);
         #1;
      end
      vif.out_ready = 1'b1;
      for (int s = 5; s <= 10; s++) applyStimulus(1'b1, 8'd255, s * 1000, 1'b1, 0);
      drain();
      checkOutput("drainAfterStall", sb.size(), 0);

      // Single-cycle input pulse: out_valid high for exactly one cycle, after the second edge.
      curUseModel   = 1'b1;
      vif.in_valid  = 1'b1;
      vif.amplitude = 8'd255;
      vif.in_sample = SB'(-700);
      @(posedge clk);
      #1;
      vif.in_valid = 1'b0;
      checkOutput("bubbleEdgeN", int'(vif.out_valid), 0);
      @(posedge clk);
      #1;
      checkOutput("bubbleEdgeN1", int'(vif.out_valid), 1);
      @(posedge clk);
      #1;
      checkOutput("bubbleEdgeN2", int'(vif.out_valid), 0);

      // Reset with both stages full discards everything; the first sample after release uses one slew step.
      applyStimulus(1'b1, 8'd200, 1111, 1'b1, 0);
      applyStimulus(1'b1, 8'd200, 2222, 1'b1, 0);
      vif.in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      checkOutput("midResetOutValid", int'(vif.out_valid), 0);
      checkOutput("midResetOutSample", int'(vif.out_sample), 0);
      checkOutput("midResetIdle", int'(vif.idle), 1);
      sb.delete();
      modelAmp = 8'd0;
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 8'd100, 256, 1'b0, 4);
      applyStimulus(1'b1, 8'd100, 256, 1'b0, 8);
      drain();
      checkOutput("finalQueueEmpty", sb.size(), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
